// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter onto a single shared memory slave
module bus_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req_valid,
  output logic               m0_req_ready,
  input  logic [WIDTH-1:0]   m0_addr,
  output logic               m0_rsp_valid,
  output logic [WIDTH-1:0]   m0_rsp_data,
  input  logic               m1_req_valid,
  output logic               m1_req_ready,
  input  logic               m1_wen,
  input  logic [WIDTH-1:0]   m1_addr,
  input  logic [WIDTH-1:0]   m1_wdata,
  input  logic [WIDTH/8-1:0] m1_wmask,
  output logic               m1_rsp_valid,
  output logic [WIDTH-1:0]   m1_rsp_data,
  output logic               s_req_valid,
  input  logic               s_req_ready,
  output logic               s_wen,
  output logic [WIDTH-1:0]   s_addr,
  output logic [WIDTH-1:0]   s_wdata,
  output logic [WIDTH/8-1:0] s_wmask,
  input  logic               s_rsp_valid,
  input  logic [WIDTH-1:0]   s_rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // 0 = m0, 1 = m1
  logic   last_grant;  // 0 = m0, 1 = m1
  logic   grant_m0;
  logic   grant_m1;
  logic   rsp_fire;

  // Grant decision in IDLE: on a tie the master that did not win last time gets the bus
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (rst && state == IDLE) begin
      if (m1_req_valid && (!m0_req_valid || !last_grant)) begin
        grant_m1 = 1'b1;
      end else if (m0_req_valid) begin
        grant_m0 = 1'b1;
      end
    end
  end

  assign m0_req_ready = grant_m0;
  assign m1_req_ready = grant_m1;

  // Slave response is forwarded straight through to the owner only while waiting for it
  always_comb begin
    rsp_fire     = (state == RESP) && s_rsp_valid;
    m0_rsp_valid = rsp_fire && !owner;
    m1_rsp_valid = rsp_fire && owner;
    m0_rsp_data  = m0_rsp_valid ? s_rsp_data : '0;
    m1_rsp_data  = m1_rsp_valid ? s_rsp_data : '0;
  end

  // Transaction FSM: latch the winner's request, present it to the slave, wait for the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b0;
      s_req_valid <= 1'b0;
      s_wen       <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_m1) begin
            state       <= REQ;
            owner       <= 1'b1;
            last_grant  <= 1'b1;
            s_req_valid <= 1'b1;
            s_wen       <= m1_wen;
            s_addr      <= m1_addr;
            s_wdata     <= m1_wdata;
            s_wmask     <= m1_wmask;
          end else if (grant_m0) begin
            state       <= REQ;
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            s_req_valid <= 1'b1;
            s_wen       <= 1'b0;
            s_addr      <= m0_addr;
            s_wdata     <= '0;
            s_wmask     <= '0;
          end
        end
        REQ: begin
          if (s_req_ready) begin
            state       <= RESP;
            s_req_valid <= 1'b0;
          end
        end
        RESP: begin
          if (s_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          s_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           m0_req_valid, m0_req_ready, m0_rsp_valid;
  logic [W-1:0]   m0_addr, m0_rsp_data;
  logic           m1_req_valid, m1_req_ready, m1_wen, m1_rsp_valid;
  logic [W-1:0]   m1_addr, m1_wdata, m1_rsp_data;
  logic [W/8-1:0] m1_wmask;
  logic           s_req_valid, s_req_ready, s_wen, s_rsp_valid;
  logic [W-1:0]   s_addr, s_wdata, s_rsp_data;
  logic [W/8-1:0] s_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding transaction record plus the previous winner
  bit             md_busy;     // a transaction has been granted and not yet answered
  bit             md_sent;     // slave has taken the request
  bit             md_owner;    // 1 = m1
  bit             md_prev;     // previous winner, 1 = m1
  bit             md_wen;
  logic [W-1:0]   md_addr, md_wdata;
  logic [W/8-1:0] md_wmask;

  bus_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_wen(m1_wen),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_wen(s_wen),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    md_busy  = 0;
    md_sent  = 0;
    md_owner = 0;
    md_prev  = 0;
    md_wen   = 0;
    md_addr  = '0;
    md_wdata = '0;
    md_wmask = '0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, then advance the model for the posedge
  task automatic step(input bit r, input bit v0, input logic [W-1:0] a0,
                      input bit v1, input bit wen, input logic [W-1:0] a1,
                      input logic [W-1:0] wd, input logic [W/8-1:0] wm,
                      input bit srdy, input bit srsp, input logic [W-1:0] sdata);
    bit e_r0, e_r1, e_sv, e_v0, e_v1;
    bit win_any, win_m1;
    @(negedge clk);
    rst = r; m0_req_valid = v0; m0_addr = a0;
    m1_req_valid = v1; m1_wen = wen; m1_addr = a1; m1_wdata = wd; m1_wmask = wm;
    s_req_ready = srdy; s_rsp_valid = srsp; s_rsp_data = sdata;
    #1;
    if (!r) model_reset();
    e_r0 = 0; e_r1 = 0; e_sv = 0; e_v0 = 0; e_v1 = 0;
    win_any = 0; win_m1 = 0;
    if (r) begin
      if (!md_busy) begin
        win_any = v0 || v1;
        win_m1  = (v0 && v1) ? !md_prev : v1;
        e_r0 = win_any && !win_m1;
        e_r1 = win_any && win_m1;
      end else if (!md_sent) begin
        e_sv = 1;
      end else if (srsp) begin
        e_v0 = !md_owner;
        e_v1 = md_owner;
      end
    end
    check("m0_req_ready", m0_req_ready, e_r0);
    check("m1_req_ready", m1_req_ready, e_r1);
    check("s_req_valid",  s_req_valid,  e_sv);
    check("m0_rsp_valid", m0_rsp_valid, e_v0);
    check("m1_rsp_valid", m1_rsp_valid, e_v1);
    check("m0_rsp_data",  m0_rsp_data,  e_v0 ? sdata : '0);
    check("m1_rsp_data",  m1_rsp_data,  e_v1 ? sdata : '0);
    check("s_addr",  s_addr,  md_addr);
    check("s_wen",   s_wen,   md_wen);
    check("s_wdata", s_wdata, md_wdata);
    check("s_wmask", s_wmask, md_wmask);
    if (r) begin
      if (win_any) begin
        md_busy  = 1;
        md_sent  = 0;
        md_owner = win_m1;
        md_prev  = win_m1;
        md_addr  = win_m1 ? a1 : a0;
        md_wen   = win_m1 ? wen : 1'b0;
        md_wdata = win_m1 ? wd : '0;
        md_wmask = win_m1 ? wm : '0;
      end else if (md_busy && !md_sent && srdy) begin
        md_sent = 1;
      end else if (md_busy && md_sent && srsp) begin
        md_busy = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 0; m0_req_valid = 0; m0_addr = '0; m1_req_valid = 0; m1_wen = 0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; s_req_ready = 0; s_rsp_valid = 0; s_rsp_data = '0;

    // Reset state, then the minimum-latency m0 fetch
    step(0, 1, 32'h1, 1, 1, 32'h2, 32'h3, 4'hF, 1, 1, 32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000413);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fresh reset: ties alternate m1, m0, m1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      step(1, 1, 32'h100 + t, 1, 0, 32'h200 + t, 0, 0, 1, 0, 0);
      step(1, 1, 32'h100 + t, 1, 0, 32'h200 + t, 0, 0, 1, 0, 0);
      step(1, 1, 32'h100 + t, 1, 0, 32'h200 + t, 0, 0, 0, 1, 32'hA0 + t);
    end

    // Spurious slave responses in IDLE and REQ, then a stalled m1 write
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    step(1, 0, 0, 1, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 0, 1, 32'hBAD);
    for (int t = 0; t < 3; t++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);

    // Reset while waiting for the response, then a normal m0 request
    step(1, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h44, 1, 0, 32'h48, 0, 0, 0, 1, 32'h99);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    step(1, 1, 32'h50, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
